// File: rtl/execute_pipe.sv
// Pipelined integer execute stage: ten-op ALU (plus RV64 word forms) feeding a
// LATENCY-deep register pipeline with valid/ready flow control, flush and a passthrough tag.
module execute_pipe #(
   parameter int XLEN    = 64,
   parameter int LATENCY = 2,
   parameter int TAG_W   = 5
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [XLEN-1:0]  opr_a_i,
   input  logic [XLEN-1:0]  opr_b_i,
   input  logic [3:0]       alu_func_i,
   input  logic             word_i,
   input  logic [TAG_W-1:0] tag_i,
   input  logic             flush_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [XLEN-1:0]  alu_res_o,
   output logic [TAG_W-1:0] tag_o
);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_SLL  = 4'd2;
   localparam logic [3:0] OP_SRL  = 4'd3;
   localparam logic [3:0] OP_SRA  = 4'd4;
   localparam logic [3:0] OP_OR   = 4'd5;
   localparam logic [3:0] OP_AND  = 4'd6;
   localparam logic [3:0] OP_XOR  = 4'd7;
   localparam logic [3:0] OP_SLTU = 4'd8;
   localparam logic [3:0] OP_SLT  = 4'd9;
   localparam int         SHW     = $clog2(XLEN);

   // Handshake: an op transfers in when in_valid_i && in_ready_o, a result transfers
   // out when out_valid_o && out_ready_i; all stages advance together whenever the
   // output slot is empty or being drained, and in_ready_o is exactly that advance.
   logic              adv;
   logic [SHW-1:0]    shamt;
   logic [4:0]        shamt_w;
   logic [31:0]       word_res;
   logic [XLEN-1:0]   word_ext;
   logic              use_word;
   logic [XLEN-1:0]   alu_res;

   logic [LATENCY-1:0] vld_q, vld_d;
   logic [XLEN-1:0]    res_q [LATENCY];
   logic [XLEN-1:0]    res_d [LATENCY];
   logic [TAG_W-1:0]   tag_q [LATENCY];
   logic [TAG_W-1:0]   tag_d [LATENCY];

   always_comb begin
      shamt    = opr_b_i[SHW-1:0];
      shamt_w  = opr_b_i[4:0];
      word_res = '0;
      case (alu_func_i)
         OP_ADD:  word_res = opr_a_i[31:0] + opr_b_i[31:0];
         OP_SUB:  word_res = opr_a_i[31:0] - opr_b_i[31:0];
         OP_SLL:  word_res = opr_a_i[31:0] << shamt_w;
         OP_SRL:  word_res = opr_a_i[31:0] >> shamt_w;
         OP_SRA:  word_res = $signed(opr_a_i[31:0]) >>> shamt_w;
         default: word_res = '0;
      endcase
      word_ext       = {XLEN{word_res[31]}};
      word_ext[31:0] = word_res;
      use_word       = (XLEN == 64) && word_i && (alu_func_i <= OP_SRA);

      alu_res = '0;
      case (alu_func_i)
         OP_ADD:  alu_res = opr_a_i + opr_b_i;
         OP_SUB:  alu_res = opr_a_i - opr_b_i;
         OP_SLL:  alu_res = opr_a_i << shamt;
         OP_SRL:  alu_res = opr_a_i >> shamt;
         OP_SRA:  alu_res = $signed(opr_a_i) >>> shamt;
         OP_OR:   alu_res = opr_a_i | opr_b_i;
         OP_AND:  alu_res = opr_a_i & opr_b_i;
         OP_XOR:  alu_res = opr_a_i ^ opr_b_i;
         OP_SLTU: alu_res[0] = opr_a_i < opr_b_i;
         OP_SLT:  alu_res[0] = $signed(opr_a_i) < $signed(opr_b_i);
         default: alu_res = '0;
      endcase
      if (use_word) alu_res = word_ext;
   end

   assign out_valid_o = vld_q[LATENCY-1];
   assign alu_res_o   = res_q[LATENCY-1];
   assign tag_o       = tag_q[LATENCY-1];
   assign adv         = !out_valid_o || out_ready_i;
   assign in_ready_o  = adv;

   always_comb begin
      vld_d = vld_q;
      res_d = res_q;
      tag_d = tag_q;
      if (adv) begin
         vld_d[0] = in_valid_i;
         if (in_valid_i) begin
            res_d[0] = alu_res;
            tag_d[0] = tag_i;
         end
         // Later stages only capture data when a valid op moves into them.
         for (int k = 1; k < LATENCY; k++) begin
            vld_d[k] = vld_q[k-1];
            if (vld_q[k-1]) begin
               res_d[k] = res_q[k-1];
               tag_d[k] = tag_q[k-1];
            end
         end
      end
      if (flush_i) vld_d = '0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         vld_q <= '0;
         for (int k = 0; k < LATENCY; k++) begin
            res_q[k] <= '0;
            tag_q[k] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         for (int k = 0; k < LATENCY; k++) begin
            res_q[k] <= res_d[k];
            tag_q[k] <= tag_d[k];
         end
      end
   end

endmodule
